ram_rr_arbiter: RTL and testbench
=================================

Name: ram_rr_arbiter

Overview:
- Controller and arbiter that shares one port of the team's 256x8 RAM between two requesters, A and B.
- After reset it sequences a full zero-clear of the memory, then grants one access per cycle round-robin.
- Read data returns to the requester with a fixed latency.
- Sits between client logic and the RAM macro's address/data/write-enable pins.

Parameters:
ADDR_W, 8, RAM address width; depth = 2**ADDR_W
DATA_W, 8, RAM data width

Ports:
clk  input  1  single clock for all logic
rst  input  1  synchronous, active-high reset
req_a  input  1  requester A access request; held until gnt_a
we_a  input  1  A: 1 = write, 0 = read; valid with req_a
add_a  input  ADDR_W  A address
din_a  input  DATA_W  A write data
gnt_a  output  1  A request accepted this cycle (combinational)
dout_a  output  DATA_W  A read data (registered)
vld_a  output  1  one-cycle pulse, dout_a updated
req_b, we_b, add_b, din_b, gnt_b, dout_b, vld_b  (same as A, for requester B)
mem_add  output  ADDR_W  RAM address
mem_din  output  DATA_W  RAM write data
mem_we  output  1  RAM write enable
mem_dout  input  DATA_W  RAM read data, valid the cycle after address is presented (registered read)
init_done  output  1  high once clear sweep is complete

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high. All state changes on posedge clk.
- Reset values:
  - state = INIT, clear counter = 0, rr pointer = "B last" so A wins the first tie.
  - init_done = 0; vld_a = vld_b = 0; dout_a = dout_b = 0; read-pending flags cleared.
- State INIT:
  - Each cycle drive mem_we=1, mem_add=counter, mem_din=0; counter increments.
  - The cycle that writes address 2**ADDR_W-1 transitions to RUN; init_done=1 from the next cycle.
  - Sweep is exactly 256 cycles at default parameters.
  - gnt_a = gnt_b = 0 throughout INIT; requests are held off, not dropped.
- State RUN:
  - At most one grant per cycle.
  - Only one requester active: it is granted.
  - Both active: grant the one not granted most recently. The pointer updates only on a grant.
  - Neither active: mem_we=0, mem_add holds its previous value, and the pointer is unchanged.
  - The granted requester's we/add/din drive mem_we/mem_add/mem_din combinationally in the grant cycle.
  - The requester may change its inputs the cycle after gnt.
- Read latency:
  - Read granted in cycle N: RAM presents data in cycle N+1, which is captured into dout_x at the end of N+1.
  - vld_x is high for exactly cycle N+2.
  - dout_x holds its value until the next completed read for that port.
  - Back-to-back reads are fully pipelined (one per cycle per the arbiter). Each port gets its own vld stream in grant order.
- Writes produce no vld.
- Hazard rule: a write granted in cycle N followed by a read of the same address in N+1 (either port) returns the new data. No bypass is needed because the RAM commits the write at the end of N.
- Fairness: with both requesters asserting continuously, grants alternate A,B,A,B. Neither requester waits more than 1 cycle in RUN.
- rst mid-operation:
  - Returns to INIT and aborts pending reads; no vld for them.
  - Clears dout_x, drops init_done the next cycle and restarts the sweep from address 0.
  - Any write in flight in the reset cycle is not issued (mem_we forced 0 in the rst cycle).
- Address and data widths pass through unchanged; no arithmetic besides the ADDR_W-bit clear counter, whose wrap ends INIT.

Test Plan:
1. Reset then idle: rst high 2 cycles, then low -> mem_we=1 for 256 consecutive cycles with mem_add 0..255 and mem_din=0; init_done rises on cycle 257; a read of address 0x37 afterwards returns dout_a=0x00 with vld_a two cycles after gnt_a.
2. Request during INIT: req_a=1 write 0x10<=0xA5 asserted at cycle 5 -> gnt_a stays 0 until the first RUN cycle, then grants; a later read of 0x10 returns 0xA5.
3. Contention: after init, req_a and req_b held high, A reading 0x01 and B reading 0x02 repeatedly -> gnt sequence A,B,A,B,...; vld_a and vld_b alternate every cycle with correct data.
4. Write-then-read hazard: A writes 0x20<=0x5C in cycle N, B reads 0x20 in N+1 -> dout_b=0x5C, vld_b in cycle N+3.
5. Reset mid-read: A read of 0x20 granted, rst asserted the next cycle -> vld_a never pulses, dout_a=0, and the INIT sweep restarts at address 0.
6. Single requester streaming: B issues 4 reads of 0x00..0x03 on consecutive cycles with A idle -> 4 consecutive vld_b pulses with data in order.

Source files
------------

// File: rtl/ram_rr_arbiter.sv
// Shares one port of a registered-read RAM between requesters A and B.
// Clears the whole array after reset, then grants one access per cycle round-robin.
module ram_rr_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] add_a,
  input  logic [DATA_W-1:0] din_a,
  output logic              gnt_a,
  output logic [DATA_W-1:0] dout_a,
  output logic              vld_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] add_b,
  input  logic [DATA_W-1:0] din_b,
  output logic              gnt_b,
  output logic [DATA_W-1:0] dout_b,
  output logic              vld_b,
  output logic [ADDR_W-1:0] mem_add,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              init_done
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_add_hold;
  logic              r_last_b;
  logic              r_init_done;
  logic              r_pend_a, r_pend_b;
  logic              r_vld_a, r_vld_b;
  logic [DATA_W-1:0] r_dout_a, r_dout_b;

  logic              w_run;
  logic              w_gnt_a, w_gnt_b;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_add;
  logic [DATA_W-1:0] w_mem_din;

  // Nothing is granted in the reset cycle, so no access can escape to the RAM.
  assign w_run = (r_state == ST_RUN) && !rst;

  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if (w_run) begin
      if (req_a && req_b) begin
        w_gnt_a = r_last_b;
        w_gnt_b = !r_last_b;
      end else begin
        w_gnt_a = req_a;
        w_gnt_b = req_b;
      end
    end
  end

  always_comb begin
    w_mem_we  = 1'b0;
    w_mem_add = r_add_hold;
    w_mem_din = '0;
    if (!rst) begin
      if (r_state == ST_INIT) begin
        w_mem_we  = 1'b1;
        w_mem_add = r_cnt;
      end else if (w_gnt_a) begin
        w_mem_we  = we_a;
        w_mem_add = add_a;
        w_mem_din = din_a;
      end else if (w_gnt_b) begin
        w_mem_we  = we_b;
        w_mem_add = add_b;
        w_mem_din = din_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_add_hold  <= '0;
      r_last_b    <= 1'b1;
      r_init_done <= 1'b0;
      r_pend_a    <= 1'b0;
      r_pend_b    <= 1'b0;
      r_vld_a     <= 1'b0;
      r_vld_b     <= 1'b0;
      r_dout_a    <= '0;
      r_dout_b    <= '0;
    end else begin
      r_add_hold <= w_mem_add;
      // Read pipeline: grant -> RAM registers data -> capture and flag valid.
      r_pend_a   <= w_gnt_a && !we_a;
      r_pend_b   <= w_gnt_b && !we_b;
      r_vld_a    <= r_pend_a;
      r_vld_b    <= r_pend_b;
      if (r_pend_a) r_dout_a <= mem_dout;
      if (r_pend_b) r_dout_b <= mem_dout;
      if (w_gnt_a) r_last_b <= 1'b0;
      else if (w_gnt_b) r_last_b <= 1'b1;
      if (r_state == ST_INIT) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == '1) begin
          r_state     <= ST_RUN;
          r_init_done <= 1'b1;
        end
      end
    end
  end

  assign gnt_a     = w_gnt_a;
  assign gnt_b     = w_gnt_b;
  assign mem_we    = w_mem_we;
  assign mem_add   = w_mem_add;
  assign mem_din   = w_mem_din;
  assign dout_a    = r_dout_a;
  assign dout_b    = r_dout_b;
  assign vld_a     = r_vld_a;
  assign vld_b     = r_vld_b;
  assign init_done = r_init_done;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Directed bench for ram_rr_arbiter with a behavioural registered-read 256x8 RAM.
module tb_ram_rr_arbiter;

  logic       clk;
  logic       rst;
  logic       req_a, we_a, req_b, we_b;
  logic [7:0] add_a, din_a, add_b, din_b;
  logic       gnt_a, gnt_b, vld_a, vld_b;
  logic [7:0] dout_a, dout_b;
  logic [7:0] mem_add, mem_din, mem_dout;
  logic       mem_we, init_done;

  int n_vec = 0;
  int n_err = 0;

  ram_rr_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .add_a(add_a), .din_a(din_a),
    .gnt_a(gnt_a), .dout_a(dout_a), .vld_a(vld_a),
    .req_b(req_b), .we_b(we_b), .add_b(add_b), .din_b(din_b),
    .gnt_b(gnt_b), .dout_b(dout_b), .vld_b(vld_b),
    .mem_add(mem_add), .mem_din(mem_din), .mem_we(mem_we),
    .mem_dout(mem_dout), .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: seeded with 0xFF so that the clear sweep is observable.
  logic [7:0] ram [256];
  logic       seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'hFF;
      seeded <= 1'b1;
    end else begin
      if (mem_we) ram[mem_add] <= mem_din;
      mem_dout <= ram[mem_add];
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] exp_s [4];

  initial begin
    exp_s = '{8'h00, 8'h11, 8'h22, 8'h33};
    rst = 1'b1;
    req_a = 0; we_a = 0; add_a = '0; din_a = '0;
    req_b = 0; we_b = 0; add_b = '0; din_b = '0;

    // Reset state
    next(); #2;
    chk("reset_state", 32'({init_done, vld_a, vld_b, dout_a, dout_b, mem_we, gnt_a, gnt_b}), 32'h0);
    next();
    rst = 1'b0;

    // Clear sweep, with a write request from A held from cycle 5
    for (int i = 0; i < 256; i++) begin
      if (i != 0) next();
      if (i == 5) begin
        req_a = 1; we_a = 1; add_a = 8'h10; din_a = 8'hA5;
      end
      #2;
      chk("init_sweep", 32'({mem_we, mem_add, mem_din, init_done, gnt_a, gnt_b}),
          32'({1'b1, i[7:0], 8'h00, 3'b000}));
    end

    // First RUN cycle: init_done up, held write granted
    next(); #2;
    chk("run0_write", 32'({init_done, gnt_a, gnt_b, mem_we, mem_add, mem_din}),
        32'({4'b1101, 8'h10, 8'hA5}));

    // Read 0x37 (cleared)
    next(); we_a = 0; add_a = 8'h37; #2;
    chk("rd37_gnt", 32'({gnt_a, mem_we, mem_add}), 32'({2'b10, 8'h37}));
    next(); req_a = 0; #2;
    chk("rd37_n1", 32'({vld_a, gnt_a, mem_we, mem_add}), 32'({3'b000, 8'h37}));
    next(); #2;
    chk("rd37_vld", 32'({vld_a, dout_a}), 32'({1'b1, 8'h00}));
    next(); #2;
    chk("rd37_n3", 32'({vld_a, dout_a}), 32'({1'b0, 8'h00}));

    // Read back 0x10 written while held off during INIT
    next(); req_a = 1; add_a = 8'h10; #2;
    chk("rd10_gnt", 32'(gnt_a), 32'(1));
    next(); req_a = 0;
    next(); #2;
    chk("rd10_vld", 32'({vld_a, dout_a}), 32'({1'b1, 8'hA5}));

    // Simultaneous writes: A was granted last, so B wins
    next();
    req_a = 1; we_a = 1; add_a = 8'h01; din_a = 8'h11;
    req_b = 1; we_b = 1; add_b = 8'h02; din_b = 8'h22;
    #2;
    chk("wr_tie_b", 32'({gnt_a, gnt_b, mem_we, mem_add, mem_din}), 32'({3'b011, 8'h02, 8'h22}));
    next(); req_b = 0; #2;
    chk("wr_then_a", 32'({gnt_a, gnt_b, mem_we, mem_add, mem_din}), 32'({3'b101, 8'h01, 8'h11}));

    // Contention: both reading continuously, grants alternate B,A,B,...
    for (int k = 0; k < 8; k++) begin
      next();
      if (k < 6) begin
        req_a = 1; we_a = 0; add_a = 8'h01;
        req_b = 1; we_b = 0; add_b = 8'h02;
      end else begin
        req_a = 0; req_b = 0;
      end
      #2;
      chk("contend_flags", 32'({gnt_a, gnt_b, vld_a, vld_b}),
          32'({(k < 6) && (k % 2 == 1), (k < 6) && (k % 2 == 0),
               (k >= 3) && (k % 2 == 1), (k >= 2) && (k % 2 == 0)}));
      if (k >= 2 && k % 2 == 0) chk("contend_dout_b", 32'(dout_b), 32'h22);
      if (k >= 3 && k % 2 == 1) chk("contend_dout_a", 32'(dout_a), 32'h11);
    end

    // Write-then-read hazard across ports
    next(); req_a = 1; we_a = 1; add_a = 8'h20; din_a = 8'h5C; #2;
    chk("haz_wr", 32'({gnt_a, mem_we, mem_add, mem_din}), 32'({2'b11, 8'h20, 8'h5C}));
    next(); req_a = 0; req_b = 1; we_b = 0; add_b = 8'h20; #2;
    chk("haz_rd", 32'({gnt_b, mem_we, mem_add}), 32'({2'b10, 8'h20}));
    next(); req_b = 0; #2;
    chk("haz_n2", 32'(vld_b), 32'(0));
    next(); #2;
    chk("haz_vld", 32'({vld_b, dout_b, dout_a}), 32'({1'b1, 8'h5C, 8'h11}));

    // Seed 0x03, then B streams four reads alone
    next(); req_a = 1; we_a = 1; add_a = 8'h03; din_a = 8'h33; #2;
    chk("wr03", 32'({gnt_a, mem_we, mem_add}), 32'({2'b11, 8'h03}));
    for (int k = 0; k < 6; k++) begin
      next();
      req_a = 0;
      if (k < 4) begin
        req_b = 1; we_b = 0; add_b = 8'(k);
      end else begin
        req_b = 0;
      end
      #2;
      chk("stream_flags", 32'({gnt_b, vld_b}), 32'({k < 4, k >= 2}));
      if (k < 4) chk("stream_add", 32'(mem_add), 32'(k));
      if (k >= 2) chk("stream_dout", 32'(dout_b), 32'(exp_s[k-2]));
    end

    // Reset the cycle after a read grant, with a write request present
    next(); req_a = 1; we_a = 0; add_a = 8'h20; #2;
    chk("rst_rd_gnt", 32'(gnt_a), 32'(1));
    next();
    req_a = 0; rst = 1;
    req_b = 1; we_b = 1; add_b = 8'h40; din_b = 8'h77;
    #2;
    chk("rst_cycle", 32'({mem_we, gnt_a, gnt_b}), 32'(0));
    next(); rst = 0; req_b = 0; #2;
    chk("rst_after1", 32'({vld_a, dout_a, init_done, mem_we, mem_add, gnt_b}),
        32'({1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0}));
    next(); #2;
    chk("rst_after2", 32'({vld_a, dout_a, dout_b, mem_we, mem_add}),
        32'({1'b0, 8'h00, 8'h00, 1'b1, 8'h01}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
